result_demux: RTL and testbench

Receive-side counterpart of the dice/traffic-light multiplexer. Takes the shared 3-bit `result` bus and the same `sel` line, and splits the stream back into a dice channel and a traffic-light channel. Each channel is checked: legal dice codes are 1–6, and traffic lights must follow the fixed light sequence. The block holds the last good value per channel and counts protocol errors. It sits directly downstream of the multiplexer, on the same clock.

---
 rtl/result_demux.sv | 127 ++++++++++++
 tb/tb_result_demux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/result_demux.sv
// Receive-side splitter for the shared dice/traffic-light result bus.
// Two stages: input capture, then per-channel decode with a light-sequence tracker and error counting.
module result_demux #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [2:0]       result,
  output logic [2:0]       dice_value,
  output logic             dice_strobe,
  output logic             red,
  output logic             amber,
  output logic             green,
  output logic             light_locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [2:0] {UNSYNC, S_R, S_RA, S_G, S_A} trk_e;

  function automatic trk_e code_to_state(input logic [2:0] code);
    case (code)
      3'b100:  return S_R;
      3'b110:  return S_RA;
      3'b001:  return S_G;
      3'b010:  return S_A;
      default: return UNSYNC;
    endcase
  endfunction

  function automatic trk_e succ(input trk_e s);
    case (s)
      S_R:     return S_RA;
      S_RA:    return S_G;
      S_G:     return S_A;
      S_A:     return S_R;
      default: return UNSYNC;
    endcase
  endfunction

  logic             s_sel_q, prev_sel_q, rst_d_q;
  logic [2:0]       s_res_q;
  trk_e             trk_q, trk_d, trk_cur, samp;
  logic [2:0]       dice_q, dice_d;
  logic             strobe_q, strobe_d;
  logic [2:0]       lights_q, lights_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // A fresh switch onto the light channel always starts from UNSYNC.
  assign trk_cur = (s_sel_q && !prev_sel_q) ? UNSYNC : trk_q;
  assign samp    = code_to_state(s_res_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    trk_d     = trk_q;
    dice_d    = dice_q;
    strobe_d  = 1'b0;
    lights_d  = lights_q;
    err_d     = 1'b0;
    if (!rst_d_q) begin
      if (!s_sel_q) begin
        if (s_res_q inside {[3'd1:3'd6]}) begin
          dice_d   = s_res_q;
          strobe_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        trk_d = trk_cur;
        if (trk_cur == UNSYNC) begin
          if (samp != UNSYNC) begin
            trk_d    = samp;
            lights_d = s_res_q;
          end else begin
            err_d = 1'b1;
          end
        end else if (samp == succ(trk_cur)) begin
          trk_d    = samp;
          lights_d = s_res_q;
        end else if (samp != trk_cur) begin
          err_d = 1'b1;
          trk_d = UNSYNC;
        end
      end
    end
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != {ERR_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      s_sel_q    <= 1'b0;
      s_res_q    <= 3'd0;
      rst_d_q    <= 1'b1;
      prev_sel_q <= 1'b0;
      trk_q      <= UNSYNC;
      dice_q     <= 3'd0;
      strobe_q   <= 1'b0;
      lights_q   <= 3'd0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s_sel_q    <= sel;
      s_res_q    <= result;
      rst_d_q    <= 1'b0;
      prev_sel_q <= s_sel_q;
      trk_q      <= trk_d;
      dice_q     <= dice_d;
      strobe_q   <= strobe_d;
      lights_q   <= lights_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign dice_value   = dice_q;
  assign dice_strobe  = strobe_q;
  assign {red, amber, green} = lights_q;
  assign light_locked = (trk_q != UNSYNC);
  assign err_pulse    = err_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_result_demux.sv
// Scoreboard bench for result_demux: a behavioural model predicts each sample's outcome,
// which is queued and compared against the outputs two cycles later.
module tb_result_demux;

  localparam int unsigned ERR_W = 8;
  localparam int          CNT_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sel = 1'b0;
  logic [2:0]       result = 3'd0;
  logic [2:0]       dice_value;
  logic             dice_strobe, red, amber, green, light_locked, err_pulse;
  logic [ERR_W-1:0] err_count;

  result_demux #(.ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .sel(sel), .result(result),
    .dice_value(dice_value), .dice_strobe(dice_strobe),
    .red(red), .amber(amber), .green(green),
    .light_locked(light_locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  dice;
    logic        strobe;
    logic [2:0]  rgb;
    logic        lock;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: light sequence as a table index.
  logic [2:0] light_codes [4] = '{3'b100, 3'b110, 3'b001, 3'b010};
  logic [2:0] m_dice, m_rgb;
  logic       m_lock, m_prev_sel;
  int         m_idx, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_dice = 3'd0; m_rgb = 3'd0; m_lock = 1'b0; m_prev_sel = 1'b0; m_idx = 0; m_cnt = 0;
  endtask

  function automatic exp_t model_step(input logic s, input logic [2:0] r);
    exp_t e;
    logic err = 1'b0, strobe = 1'b0;
    int   j = -1;
    if (!s) begin
      if (r >= 3'd1 && r <= 3'd6) begin m_dice = r; strobe = 1'b1; end
      else err = 1'b1;
    end else begin
      if (!m_prev_sel) m_lock = 1'b0;
      for (int k = 0; k < 4; k++) if (light_codes[k] == r) j = k;
      if (!m_lock) begin
        if (j >= 0) begin m_lock = 1'b1; m_idx = j; m_rgb = r; end
        else err = 1'b1;
      end else if (j == (m_idx + 1) % 4) begin
        m_idx = j; m_rgb = r;
      end else if (j != m_idx) begin
        err = 1'b1; m_lock = 1'b0;
      end
    end
    m_prev_sel = s;
    if (err && m_cnt < CNT_MAX) m_cnt++;
    e.dice = m_dice; e.strobe = strobe; e.rgb = m_rgb;
    e.lock = m_lock; e.err = err; e.cnt = m_cnt;
    return e;
  endfunction

  task automatic compare_front();
    exp_t e;
    e = exp_q.pop_front();
    check("dice_value", 32'(dice_value), 32'(e.dice));
    check("dice_strobe", 32'(dice_strobe), 32'(e.strobe));
    check("lights", 32'({red, amber, green}), 32'(e.rgb));
    check("light_locked", 32'(light_locked), 32'(e.lock));
    check("err_pulse", 32'(err_pulse), 32'(e.err));
    check("err_count", 32'(err_count), e.cnt);
  endtask

  task automatic drive_push(input logic s, input logic [2:0] r);
    sel = s;
    result = r;
    exp_q.push_back(model_step(s, r));
  endtask

  task automatic step(input logic s, input logic [2:0] r);
    @(negedge clk);
    if (exp_q.size() >= 2) compare_front();
    drive_push(s, r);
  endtask

  task automatic drain();
    repeat (2) begin
      @(negedge clk);
      if (exp_q.size() > 0) compare_front();
    end
  endtask

  // One reset edge, check the cleared outputs, then present the first sample on release.
  task automatic do_reset(input logic s, input logic [2:0] r);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_dice_value", 32'(dice_value), 32'd0);
    check("rst_dice_strobe", 32'(dice_strobe), 32'd0);
    check("rst_lights", 32'({red, amber, green}), 32'd0);
    check("rst_light_locked", 32'(light_locked), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    drive_push(s, r);
  endtask

  initial begin
    model_reset();

    // Dice value held for three samples, then two illegal codes.
    do_reset(1'b0, 3'd5);
    step(1'b0, 3'd5);
    step(1'b0, 3'd5);
    step(1'b0, 3'd7);
    step(1'b0, 3'd0);

    // Full light sequence with one repeat.
    step(1'b1, 3'b100);
    step(1'b1, 3'b100);
    step(1'b1, 3'b110);
    step(1'b1, 3'b001);
    step(1'b1, 3'b010);
    step(1'b1, 3'b100);

    // Skip from R to G errors, repeating G re-acquires.
    step(1'b1, 3'b001);
    step(1'b1, 3'b001);
    step(1'b1, 3'b010);

    // Channel toggle: first light sample acquires without error.
    step(1'b0, 3'd3);
    step(1'b1, 3'b010);
    step(1'b1, 3'b100);

    // Toggle together with an illegal code: one error, no lock.
    step(1'b0, 3'd2);
    step(1'b1, 3'b111);
    step(1'b1, 3'b000);
    step(1'b1, 3'b110);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    // Saturation of the error counter.
    do_reset(1'b0, 3'd7);
    for (int i = 0; i < 259; i++)
      step(1'b0, 3'd7);
    drain();
    check("sat_err_count", 32'(err_count), 32'(CNT_MAX));
    check("sat_err_pulse", 32'(err_pulse), 32'd1);

    // Reset in the middle of a saturated error stream, then resume.
    do_reset(1'b0, 3'd4);
    step(1'b1, 3'b110);
    step(1'b1, 3'b100);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
